mem_core_run_sched: RTL and testbench

Run scheduler for one `memory_core` tile. On a start request it streams configuration beats into the core's config port with the core clock-gated. It then issues a one-cycle flush and drives `ren_in` until a programmed number of valid reads has been observed. A watchdog aborts runs that stop producing data. It sits between the tile-level controller and the core's `clk_en`/`flush`/`ren_in`/config pins.

---
 rtl/mem_core_sched_pkg.sv | 26 ++
 rtl/mem_core_watchdog.sv | 32 +++
 rtl/mem_core_run_sched.sv | 187 ++++++++++++++++++
 tb/tb_mem_core_run_sched.sv | 555 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_core_sched_pkg.sv
// Shared types and defaults for the memory_core run scheduler.
// The core-register config target is encoded as cfg_sram == N_SRAM.
package mem_core_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_FIN   = 3'd4
    } sched_state_t;

    localparam int DEF_CFG_W  = 32;
    localparam int DEF_N_SRAM = 4;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_WDOG   = 64;

    // A beat whose target equals the SRAM count addresses core registers.
    function automatic logic is_core_sel(
        input int sel,
        input int n_sram
    );
        return sel == n_sram;
    endfunction

endpackage

// File: rtl/mem_core_watchdog.sv
// Loadable down-counter watchdog with clear and enable.
// Expires on the enabled cycle that would take the count from 1 to 0.
module mem_core_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    // Clear idles the counter; load rearms it; enable counts down.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(LIMIT);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = i_en && !i_load && !i_clr
                    && (r_cnt == W'(1));

endmodule

// File: rtl/mem_core_run_sched.sv
// Run scheduler for one memory_core tile: config streaming,
// flush, counted reads with watchdog, abort and completion.
module mem_core_run_sched
    import mem_core_sched_pkg::*;
#(
    parameter int CFG_W  = DEF_CFG_W,
    parameter int N_SRAM = DEF_N_SRAM,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WDOG   = DEF_WDOG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         run_len,
    input  logic                     abort,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CFG_W-1:0]         cfg_addr,
    input  logic [CFG_W-1:0]         cfg_data,
    input  logic [$clog2(N_SRAM):0]  cfg_sram,
    input  logic                     cfg_last,
    input  logic                     stall,
    input  logic                     valid_out,
    output logic [CFG_W-1:0]         config_addr,
    output logic [CFG_W-1:0]         config_data,
    output logic                     config_write,
    output logic [N_SRAM-1:0]        config_en_sram,
    output logic                     clk_en,
    output logic                     flush,
    output logic                     ren_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CNT_W-1:0]         rd_count
);

    sched_state_t r_state;
    sched_state_t w_next;

    logic [CNT_W-1:0]  r_run_len;
    logic [CNT_W-1:0]  r_rd_count;
    logic              r_err;
    logic [CFG_W-1:0]  r_cfg_addr;
    logic [CFG_W-1:0]  r_cfg_data;
    logic              r_cfg_write;
    logic [N_SRAM-1:0] r_en_sram;

    logic              w_accept;
    logic              w_start;
    logic              w_ren;
    logic              w_hit;
    logic              w_last_hit;
    logic [CNT_W-1:0]  w_rd_inc;
    logic [N_SRAM-1:0] w_onehot;
    logic              w_wd_clr;
    logic              w_wd_load;
    logic              w_wd_expire;

    assign w_accept = (r_state == S_CFG)
                    && cfg_valid && !abort;
    assign w_start  = (r_state == S_IDLE)
                    && start && !abort;
    assign w_ren    = (r_state == S_RUN) && !stall
                    && (r_rd_count < r_run_len);
    assign w_hit    = w_ren && valid_out && !abort;
    assign w_rd_inc = r_rd_count + 1'b1;
    assign w_last_hit = w_hit && (w_rd_inc == r_run_len);

    // Decode the beat target into SRAM enables; core target is all-zero.
    always_comb begin
        w_onehot = '0;
        if (!is_core_sel(int'(cfg_sram), N_SRAM)) begin
            for (int i = 0; i < N_SRAM; i++) begin
                if (int'(cfg_sram) == i) begin
                    w_onehot[i] = 1'b1;
                end
            end
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_CFG;
                end
                S_CFG: begin
                    if (w_accept && cfg_last) w_next = S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_run_len == '0) w_next = S_FIN;
                    else                 w_next = S_RUN;
                end
                S_RUN: begin
                    if (w_last_hit || w_wd_expire) w_next = S_FIN;
                end
                S_FIN: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run length latch, read counter and watchdog error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_len  <= '0;
            r_rd_count <= '0;
            r_err      <= 1'b0;
        end else if (w_start) begin
            r_run_len  <= run_len;
            r_rd_count <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_hit) begin
                r_rd_count <= w_rd_inc;
            end
            if (!abort && !w_last_hit && w_wd_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Config register stage: one write pulse per accepted beat.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_cfg_write <= 1'b0;
            r_en_sram   <= '0;
        end else begin
            r_cfg_write <= w_accept;
            r_en_sram   <= w_accept ? w_onehot : '0;
            if (w_accept) begin
                r_cfg_addr <= cfg_addr;
                r_cfg_data <= cfg_data;
            end
        end
    end

    // Watchdog is armed in FLUSH and rearmed by any valid read.
    assign w_wd_clr  = abort || ((r_state != S_RUN)
                    && (r_state != S_FLUSH));
    assign w_wd_load = (r_state == S_FLUSH) || valid_out;

    mem_core_watchdog #(
        .LIMIT (WDOG)
    ) u_wdog (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clr    (w_wd_clr),
        .i_load   (w_wd_load),
        .i_en     (w_ren),
        .o_expire (w_wd_expire)
    );

    assign cfg_ready      = (r_state == S_CFG) && !abort;
    assign config_addr    = r_cfg_addr;
    assign config_data    = r_cfg_data;
    assign config_write   = r_cfg_write;
    assign config_en_sram = r_en_sram;
    assign clk_en         = (r_state == S_FLUSH)
                         || (r_state == S_RUN);
    assign flush          = (r_state == S_FLUSH);
    assign ren_in         = w_ren;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FIN) && !abort;
    assign err            = done && r_err;
    assign rd_count       = r_rd_count;

endmodule

// File: tb/tb_mem_core_run_sched.sv
// Self-checking bench for mem_core_run_sched.
// Config beats are scoreboarded; run results checked per scenario.
module tb_mem_core_run_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] run_len;
    logic        abort;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  cfg_sram;
    logic        cfg_last;
    logic        stall;
    logic        valid_out;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_write;
    logic [3:0]  config_en_sram;
    logic        clk_en;
    logic        flush;
    logic        ren_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd_count;

    mem_core_run_sched #(
        .CFG_W  (32),
        .N_SRAM (4),
        .CNT_W  (32),
        .WDOG   (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .run_len        (run_len),
        .abort          (abort),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_sram       (cfg_sram),
        .cfg_last       (cfg_last),
        .stall          (stall),
        .valid_out      (valid_out),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .config_write   (config_write),
        .config_en_sram (config_en_sram),
        .clk_en         (clk_en),
        .flush          (flush),
        .ren_in         (ren_in),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rd_count       (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  en;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_flush = 0;
    int n_ren  = 0;
    int n_done = 0;

    // Scoreboard for config writes plus event counters.
    always @(negedge clk) begin
        if (!reset) begin
            if (config_write) begin
                n_wr++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cfg_write_unexpected addr=%h",
                             config_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (config_addr !== mon_e.a
                        || config_data !== mon_e.d
                        || config_en_sram !== mon_e.en) begin
                        n_fail++;
                        $display("FAIL cfg_write got %h/%h/%b want %h/%h/%b",
                                 config_addr, config_data,
                                 config_en_sram, mon_e.a,
                                 mon_e.d, mon_e.en);
                    end
                end
            end
            if (flush)  n_flush++;
            if (ren_in) n_ren++;
            if (done)   n_done++;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] len);
        start = 1'b1;
        run_len = len;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy got %b want 1", busy);
        end
        tick();
    endtask

    task automatic send_beat(
        input logic [31:0] a,
        input logic [31:0] d,
        input logic [2:0]  s,
        input logic        last
    );
        bit   ok;
        wr_t  e;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_sram  = s;
        cfg_last  = last;
        ok = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cfg_ready_timeout got 0 want 1");
        end else begin
            e.a  = a;
            e.d  = d;
            e.en = (s < 3'd4) ? (4'b0001 << s) : 4'b0000;
            exp_q.push_back(e);
        end
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic wait_done(
        input  int          maxc,
        output bit          seen,
        output logic        e,
        output logic [31:0] rc,
        output int          dcyc,
        output int          lastv
    );
        seen = 0;
        e = 1'bx;
        rc = 'x;
        dcyc = -1;
        lastv = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (ren_in && valid_out) lastv = k;
            if (done) begin
                seen = 1;
                e = err;
                rc = rd_count;
                dcyc = k;
                break;
            end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout got 0 want 1");
        end
    endtask

    task automatic wait_count(input logic [31:0] tgt);
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rd_count >= tgt) begin
                ok = 1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rd_count_wait got %0d want %0d",
                     rd_count, tgt);
        end
    endtask

    task automatic check_idle_after(input string nm);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle busy=%b err=%b want 0/0",
                     nm, busy, err);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_chk++;
        if ({busy, done, err, cfg_ready, clk_en, flush,
             ren_in, config_write} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0",
                     {busy, done, err, cfg_ready, clk_en,
                      flush, ren_in, config_write});
        end
        n_chk++;
        if (config_en_sram !== 4'b0 || rd_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data en=%b rd=%0d want 0/0",
                     config_en_sram, rd_count);
        end
        n_chk++;
        if (config_addr !== 32'd0 || config_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cfg addr=%h data=%h want 0/0",
                     config_addr, config_data);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        int b_wr, b_fl, b_ren, dc, lv;
        bit seen;
        logic e;
        logic [31:0] rc;
        b_wr = n_wr; b_fl = n_flush; b_ren = n_ren;
        valid_out = 1'b1;
        do_start(32'd27);
        send_beat(32'h0, 32'h1111, 3'd4, 1'b0);
        send_beat(32'h4, 32'h2222, 3'd4, 1'b0);
        send_beat(32'h8, 32'h3333, 3'd4, 1'b1);
        wait_done(100, seen, e, rc, dc, lv);
        n_chk++;
        if (rc !== 32'd27 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result rd=%0d err=%b want 27/0",
                     rc, e);
        end
        n_chk++;
        if (dc != lv + 1) begin
            n_fail++;
            $display("FAIL basic_done_lat got %0d want %0d",
                     dc, lv + 1);
        end
        check_idle_after("basic");
        valid_out = 1'b0;
        n_chk++;
        if (n_wr - b_wr != 3 || n_flush - b_fl != 1) begin
            n_fail++;
            $display("FAIL basic_cfg wr=%0d fl=%0d want 3/1",
                     n_wr - b_wr, n_flush - b_fl);
        end
        n_chk++;
        if (n_ren - b_ren != 27) begin
            n_fail++;
            $display("FAIL basic_ren got %0d want 27",
                     n_ren - b_ren);
        end
    endtask

    task automatic test_sram_gap();
        int b_wr, dc, lv;
        bit seen;
        logic e;
        logic [31:0] rc;
        b_wr = n_wr;
        valid_out = 1'b1;
        do_start(32'd2);
        send_beat(32'h10, 32'hA5A5, 3'd2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (clk_en !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_clk_en got %b want 0", clk_en);
            end
            tick();
        end
        send_beat(32'h14, 32'h5A5A, 3'd2, 1'b1);
        @(negedge clk);
        n_chk++;
        if (flush !== 1'b1 || clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_flush fl=%b ce=%b want 1/1",
                     flush, clk_en);
        end
        wait_done(50, seen, e, rc, dc, lv);
        n_chk++;
        if (rc !== 32'd2 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_result rd=%0d err=%b want 2/0",
                     rc, e);
        end
        check_idle_after("gap");
        valid_out = 1'b0;
        n_chk++;
        if (n_wr - b_wr != 2) begin
            n_fail++;
            $display("FAIL gap_writes got %0d want 2",
                     n_wr - b_wr);
        end
    endtask

    task automatic test_zero_len();
        int b_fl, b_ren, dc, lv;
        bit seen;
        logic e;
        logic [31:0] rc;
        b_fl = n_flush; b_ren = n_ren;
        do_start(32'd0);
        send_beat(32'hC0, 32'h1, 3'd0, 1'b1);
        wait_done(10, seen, e, rc, dc, lv);
        n_chk++;
        if (rc !== 32'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result rd=%0d err=%b want 0/0",
                     rc, e);
        end
        check_idle_after("zero");
        n_chk++;
        if (n_ren - b_ren != 0 || n_flush - b_fl != 1) begin
            n_fail++;
            $display("FAIL zero_events ren=%0d fl=%0d want 0/1",
                     n_ren - b_ren, n_flush - b_fl);
        end
    endtask

    task automatic test_watchdog();
        int b_ren, dc, lv;
        bit seen;
        logic e;
        logic [31:0] rc;
        b_ren = n_ren;
        valid_out = 1'b0;
        do_start(32'd5);
        send_beat(32'h20, 32'h7, 3'd4, 1'b1);
        wait_done(200, seen, e, rc, dc, lv);
        n_chk++;
        if (e !== 1'b1 || rc !== 32'd0) begin
            n_fail++;
            $display("FAIL wdog_result err=%b rd=%0d want 1/0",
                     e, rc);
        end
        check_idle_after("wdog");
        n_chk++;
        if (n_ren - b_ren != 64) begin
            n_fail++;
            $display("FAIL wdog_ren got %0d want 64",
                     n_ren - b_ren);
        end
    endtask

    task automatic test_stall();
        int dc, lv;
        bit seen;
        logic e;
        logic [31:0] rc, held;
        valid_out = 1'b1;
        do_start(32'd8);
        send_beat(32'h30, 32'h9, 3'd1, 1'b1);
        wait_count(32'd3);
        tick();
        stall = 1'b1;
        held = rd_count;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_chk++;
            if (ren_in !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ren ren=%b done=%b want 0/0",
                         ren_in, done);
            end
            tick();
        end
        n_chk++;
        if (rd_count !== held) begin
            n_fail++;
            $display("FAIL stall_hold got %0d want %0d",
                     rd_count, held);
        end
        stall = 1'b0;
        wait_done(50, seen, e, rc, dc, lv);
        n_chk++;
        if (rc !== 32'd8 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_result rd=%0d err=%b want 8/0",
                     rc, e);
        end
        check_idle_after("stall");
        valid_out = 1'b0;
    endtask

    task automatic test_abort();
        int b_done;
        logic [31:0] held;
        b_done = n_done;
        // abort in CFG with a beat on offer
        do_start(32'd4);
        abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_last = 1'b1;
        cfg_sram = 3'd1;
        tick();
        abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_last = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, config_write, config_en_sram, clk_en,
             flush, ren_in} !== 9'b0) begin
            n_fail++;
            $display("FAIL abort_cfg got %b want 0",
                     {busy, config_write, config_en_sram,
                      clk_en, flush, ren_in});
        end
        tick();
        // abort in RUN
        valid_out = 1'b1;
        do_start(32'd20);
        send_beat(32'h40, 32'h2, 3'd3, 1'b1);
        wait_count(32'd5);
        tick();
        abort = 1'b1;
        held = rd_count;
        tick();
        abort = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, config_write, config_en_sram, clk_en,
             flush, ren_in} !== 9'b0) begin
            n_fail++;
            $display("FAIL abort_run got %b want 0",
                     {busy, config_write, config_en_sram,
                      clk_en, flush, ren_in});
        end
        n_chk++;
        if (rd_count !== held) begin
            n_fail++;
            $display("FAIL abort_hold got %0d want %0d",
                     rd_count, held);
        end
        tick();
        // reset in RUN
        do_start(32'd20);
        send_beat(32'h50, 32'h3, 3'd4, 1'b1);
        wait_count(32'd3);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_chk++;
        if ({busy, done, clk_en, flush, ren_in,
             config_write} !== 6'b0 || rd_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_run ctl=%b rd=%0d want 0/0",
                     {busy, done, clk_en, flush, ren_in,
                      config_write}, rd_count);
        end
        tick();
        reset = 1'b0;
        valid_out = 1'b0;
        tick();
        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort busy=%b want 0", busy);
        end
        for (int k = 0; k < 4; k++) tick();
        n_chk++;
        if (n_done != b_done) begin
            n_fail++;
            $display("FAIL abort_no_done got %0d want 0",
                     n_done - b_done);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        run_len = '0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_sram = '0;
        cfg_last = 1'b0;
        stall = 1'b0;
        valid_out = 1'b0;
        test_reset();
        test_basic_run();
        test_sram_gap();
        test_zero_len();
        test_watchdog();
        test_stall();
        test_abort();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cfg_queue_left got %0d want 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
